wt_mem_req_arbiter: RTL

WT_MEM_REQ_ARBITER -- requirements
Module: wt_mem_req_arbiter

---
 rtl/wt_mem_req_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wt_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// wt_mem_req_arbiter
// Round-robin arbiter that funnels memory requests from NumClients caches
// onto one downstream request channel and routes returns back to their
// source. Each client has a credit counter that limits its outstanding
// reads to MaxOutstanding. Writes do not consume credit.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clear_i               synchronous flush of FSM, credits and RR pointer
//   stall_i               inhibits new grants (an in-flight one completes)
//   req_i / ack_o         per-client request, one-cycle acknowledge
//   addr_i, wdata_i,      per-client payload, flattened (client c at
//   txid_i, we_i          slice [c*W +: W])
//   mem_req_o/mem_ack_i   downstream handshake
//   mem_*_o               registered payload of the granted client
//   rtrn_*_i              downstream return, tagged with source client
//   rtrn_*_o              return routed to its client, one cycle later
//   busy_o                a transfer or any read is outstanding
//   err_o                 one-cycle pulse for a dropped (illegal) return
// ---------------------------------------------------------------------------
module wt_mem_req_arbiter #(
  parameter int NumClients     = 3,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int TxIdWidth      = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            stall_i,
  input  logic [NumClients-1:0]           req_i,
  output logic [NumClients-1:0]           ack_o,
  input  logic [NumClients*AddrWidth-1:0] addr_i,
  input  logic [NumClients*DataWidth-1:0] wdata_i,
  input  logic [NumClients*TxIdWidth-1:0] txid_i,
  input  logic [NumClients-1:0]           we_i,
  output logic                            mem_req_o,
  input  logic                            mem_ack_i,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic                            mem_we_o,
  output logic [TxIdWidth-1:0]            mem_txid_o,
  output logic [$clog2(NumClients)-1:0]   mem_src_o,
  input  logic                            rtrn_vld_i,
  input  logic [$clog2(NumClients)-1:0]   rtrn_src_i,
  input  logic [TxIdWidth-1:0]            rtrn_txid_i,
  input  logic [DataWidth-1:0]            rtrn_data_i,
  output logic [NumClients-1:0]           rtrn_vld_o,
  output logic [TxIdWidth-1:0]            rtrn_txid_o,
  output logic [DataWidth-1:0]            rtrn_data_o,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int SrcW = $clog2(NumClients);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [SrcW-1:0]                src_q, src_d;
  logic [SrcW-1:0]                rr_q, rr_d;
  logic [AddrWidth-1:0]           addr_q, addr_d;
  logic [DataWidth-1:0]           wdata_q, wdata_d;
  logic                           we_q, we_d;
  logic [TxIdWidth-1:0]           txid_q, txid_d;
  logic [NumClients-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumClients-1:0]          rvld_q, rvld_d;
  logic [TxIdWidth-1:0]           rtxid_q, rtxid_d;
  logic [DataWidth-1:0]           rdata_q, rdata_d;
  logic                           err_q, err_d;

  logic                           found;
  logic [SrcW-1:0]                win;
  logic [SrcW-1:0]                cidx;
  int                             idx;
  logic                           rtrn_ok;
  logic                           inc, dec;

  // Round-robin search: scan from rr_q upward with wrap, first eligible wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cidx  = '0;
    for (int k = 0; k < NumClients; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NumClients) idx = idx - NumClients;
      cidx = SrcW'(idx);
      if (!found && req_i[cidx] && (cnt_q[cidx] < CntW'(MaxOutstanding))) begin
        found = 1'b1;
        win   = cidx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    txid_d  = txid_q;
    cnt_d   = cnt_q;
    rvld_d  = '0;
    rtxid_d = rtxid_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    ack_o   = '0;
    rtrn_ok = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found && !stall_i) begin
          state_d = WAIT_ACK;
          src_d   = win;
          addr_d  = addr_i[int'(win)*AddrWidth +: AddrWidth];
          wdata_d = wdata_i[int'(win)*DataWidth +: DataWidth];
          txid_d  = txid_i[int'(win)*TxIdWidth +: TxIdWidth];
          we_d    = we_i[win];
          rr_d    = (win == SrcW'(NumClients - 1)) ? '0 : win + SrcW'(1);
        end
      end
      WAIT_ACK: begin
        if (mem_ack_i) begin
          state_d      = IDLE;
          ack_o[src_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A return is legal only for an existing client that has a read pending;
    // an out-of-range source never matches any client index.
    for (int c = 0; c < NumClients; c++) begin
      if (rtrn_vld_i && (rtrn_src_i == SrcW'(c)) && (cnt_q[c] != '0)) begin
        rtrn_ok   = 1'b1;
        rvld_d[c] = 1'b1;
      end
    end
    if (rtrn_ok) begin
      rtxid_d = rtrn_txid_i;
      rdata_d = rtrn_data_i;
    end
    err_d = rtrn_vld_i && !rtrn_ok;

    for (int c = 0; c < NumClients; c++) begin
      inc = ack_o[c] && !we_q;
      dec = rvld_d[c];
      if (inc && !dec) cnt_d[c] = cnt_q[c] + CntW'(1);
      else if (dec && !inc) cnt_d[c] = cnt_q[c] - CntW'(1);
    end

    // Flush wins over grant, ack and return.
    if (clear_i) begin
      state_d = IDLE;
      rr_d    = '0;
      cnt_d   = '0;
      ack_o   = '0;
      rvld_d  = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      txid_q  <= '0;
      cnt_q   <= '0;
      rvld_q  <= '0;
      rtxid_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      txid_q  <= txid_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rtxid_q <= rtxid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = (state_q == WAIT_ACK);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign mem_txid_o  = txid_q;
  assign mem_src_o   = src_q;
  assign rtrn_vld_o  = rvld_q;
  assign rtrn_txid_o = rtxid_q;
  assign rtrn_data_o = rdata_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q == WAIT_ACK) || (|cnt_q);

endmodule
